// File: rtl/exe_muldiv_stage.sv
// Execute-stage multiply/divide unit: MUL class with fixed latency, iterative
// restoring divider (1 bit/cycle), COPY1 passthrough, valid/allowin handshake.
module exe_muldiv_stage #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ds_to_es_valid,
    output logic            es_allowin,
    output logic            es_to_ms_valid,
    input  logic            ms_allowin,
    input  logic            flush,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] op2_data,
    input  logic [4:0]      rd_in,
    input  logic            rd_wen_in,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            rd_wen_out,
    output logic            busy
);

    localparam int CW       = $clog2(XLEN + 2);
    localparam int MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic            es_valid;
    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res_q, dvd_q, dsr_q, rem_q;
    logic            q_neg, r_neg, is_rem;
    logic [4:0]      rd_q;
    logic            rd_wen_q;

    logic es_ready_go, cap;

    assign es_ready_go    = es_valid && (state == S_DONE);
    assign busy           = es_valid && !es_ready_go;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_ready_go;
    assign cap            = ds_to_es_valid && es_allowin && !flush;

    assign result     = res_q;
    assign rd_out     = rd_q;
    assign rd_wen_out = rd_wen_q && es_valid;

    // Capture-time decode: the product and divide special cases resolve here,
    // so the MUL state only burns latency and the divider only sees real work.
    logic            op1_neg, op2_neg, div_signed, div_rem, div_zero, div_ovf;
    logic            ma_s, mb_s;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0] a_mag, b_mag, cap_res;
    logic [1:0]      cap_state;

    assign op1_neg    = op1_data[XLEN-1];
    assign op2_neg    = op2_data[XLEN-1];
    assign div_signed = !op[0];
    assign div_rem    = op[1];
    assign div_zero   = (op2_data == '0);
    assign div_ovf    = div_signed && (op1_data == {1'b1, {(XLEN-1){1'b0}}})
                        && (op2_data == '1);
    assign ma_s       = ((op[1:0] == 2'd1) || (op[1:0] == 2'd2)) && op1_neg;
    assign mb_s       = (op[1:0] == 2'd1) && op2_neg;
    assign ma         = {{XLEN{ma_s}}, op1_data};
    assign mb         = {{XLEN{mb_s}}, op2_data};
    assign prod       = ma * mb;
    assign a_mag      = (div_signed && op1_neg) ? -op1_data : op1_data;
    assign b_mag      = (div_signed && op2_neg) ? -op2_data : op2_data;

    always_comb begin
        cap_state = S_DONE;
        cap_res   = op1_data;
        if (!op[3]) begin
            if (!op[2]) begin
                cap_state = (MUL_LAT == 1) ? S_DONE : S_MUL;
                cap_res   = (op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end else if (div_zero) begin
                cap_res = div_rem ? op1_data : '1;
            end else if (div_ovf) begin
                cap_res = div_rem ? '0 : op1_data;
            end else begin
                cap_state = S_DIV;
                cap_res   = '0;
            end
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [XLEN:0]   rsh, diff;
    logic            qbit;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    assign rsh    = {rem_q, dvd_q[XLEN-1]};
    assign diff   = rsh - {1'b0, dsr_q};
    assign qbit   = !diff[XLEN];
    assign rem_nx = qbit ? diff[XLEN-1:0] : rsh[XLEN-1:0];
    assign quo_nx = {dvd_q[XLEN-2:0], qbit};
    assign q_fix  = q_neg ? -quo_nx : quo_nx;
    assign r_fix  = r_neg ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es_valid <= 1'b0;
            state    <= S_IDLE;
            cnt      <= '0;
            res_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_rem   <= 1'b0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
        end else if (flush) begin
            es_valid <= 1'b0;
            state    <= S_IDLE;
            cnt      <= '0;
        end else if (cap) begin
            es_valid <= 1'b1;
            state    <= cap_state;
            cnt      <= '0;
            res_q    <= cap_res;
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            rem_q    <= '0;
            q_neg    <= div_signed && (op1_neg ^ op2_neg);
            r_neg    <= div_signed && op1_neg;
            is_rem   <= div_rem;
            rd_q     <= rd_in;
            rd_wen_q <= rd_wen_in;
        end else begin
            case (state)
                S_MUL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MUL_LAST)) state <= S_DONE;
                end
                S_DIV: begin
                    cnt   <= cnt + CW'(1);
                    dvd_q <= quo_nx;
                    rem_q <= rem_nx;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= S_DONE;
                        res_q <= is_rem ? r_fix : q_fix;
                    end
                end
                S_DONE: begin
                    if (ms_allowin) begin
                        es_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Self-checking bench for exe_muldiv_stage: directed vector table, handshake
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_exe_muldiv_stage;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ds_to_es_valid, es_allowin, es_to_ms_valid, ms_allowin, flush;
    logic [3:0]      op;
    logic [XLEN-1:0] op1_data, op2_data, result;
    logic [4:0]      rd_in, rd_out;
    logic            rd_wen_in, rd_wen_out, busy;

    int errors = 0;
    int checks = 0;

    exe_muldiv_stage #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .flush(flush), .op(op), .op1_data(op1_data), .op2_data(op2_data),
        .rd_in(rd_in), .rd_wen_in(rd_wen_in),
        .result(result), .rd_out(rd_out), .rd_wen_out(rd_wen_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic on wide integers.
    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (o)
            4'd0: begin p = ua * ub; return p[31:0]; end
            4'd1: begin p = sa * sb; return p[63:32]; end
            4'd2: begin p = sa * ub; return p[63:32]; end
            4'd3: begin p = ua * ub; return p[63:32]; end
            4'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            4'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            4'd7: return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        if (o >= 4'd8) return 1;
        if (o < 4'd4) return MUL_LAT;
        if (b == 0) return 1;
        if ((o == 4'd4 || o == 4'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one op from an idle stage (called #1 after a rising edge), measure
    // cycles to es_to_ms_valid, optionally hold it with ms_allowin low.
    task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int stall);
        int cyc;
        logic busy_ok;
        logic [4:0] rd;
        rd = 5'($urandom_range(0, 31));
        chk({name, " allowin"}, 64'(es_allowin), 64'd1);
        ds_to_es_valid = 1'b1; op = o; op1_data = a; op2_data = b;
        rd_in = rd; rd_wen_in = 1'b1;
        ms_allowin = (stall == 0);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!es_to_ms_valid && cyc < 200) begin
            if (!busy || es_allowin) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, " result"}, 64'(result), 64'(exp_res));
        chk({name, " busy"}, 64'(busy_ok), 64'd1);
        chk({name, " rd"}, {58'd0, rd_wen_out, rd_out}, {58'd0, 1'b1, rd});
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({name, " hold"}, {30'd0, es_to_ms_valid, es_allowin, result},
                {30'd0, 1'b1, 1'b0, exp_res});
        end
        ms_allowin = 1'b1;
        @(posedge clk); #1;
        chk({name, " retire"}, 64'(es_to_ms_valid), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        int          lat;
    } vec_t;

    vec_t vt[15];

    initial begin
        vt[0]  = '{"mulhu_max",  4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vt[1]  = '{"mul_max",    4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2};
        vt[2]  = '{"mulh_m1",    4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vt[3]  = '{"mulhsu_m1",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vt[4]  = '{"div_m7_2",   4'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vt[5]  = '{"rem_m7_2",   4'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vt[6]  = '{"div_7_m2",   4'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vt[7]  = '{"rem_7_m2",   4'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vt[8]  = '{"divu_5_0",   4'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vt[9]  = '{"remu_5_0",   4'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vt[10] = '{"rem_ovf",    4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vt[11] = '{"div_ovf",    4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vt[12] = '{"divu_100_7", 4'd5, 32'd100,       32'd7,         32'd14,        33};
        vt[13] = '{"remu_100_7", 4'd7, 32'd100,       32'd7,         32'd2,         33};
        vt[14] = '{"copy1",      4'd9, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1};

        rst_n = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b1; flush = 1'b0;
        op = '0; op1_data = '0; op2_data = '0; rd_in = '0; rd_wen_in = 1'b0;
        #12;
        chk("reset outputs", {56'd0, es_to_ms_valid, busy, es_allowin, rd_wen_out, 4'd0},
            {56'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        chk("reset result", {27'd0, rd_out, result}, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) do_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat, 0);

        // Completion under backpressure, with a COPY1 waiting upstream.
        begin
            int cyc;
            ms_allowin = 1'b0;
            ds_to_es_valid = 1'b1; op = 4'd5; op1_data = 32'd100; op2_data = 32'd7;
            rd_in = 5'd5; rd_wen_in = 1'b1;
            @(posedge clk); #1;
            op = 4'd9; op1_data = 32'hCAFE_0001; op2_data = 32'd0; rd_in = 5'd7;
            cyc = 1;
            while (!es_to_ms_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
            chk("bp latency", 64'(cyc), 64'd33);
            for (int k = 0; k < 3; k++) begin
                chk("bp hold", {25'd0, es_to_ms_valid, es_allowin, rd_wen_out, rd_out, result},
                    {25'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'd14});
                if (k < 2) begin @(posedge clk); #1; end
            end
            ms_allowin = 1'b1;
            #1 chk("bp allowin", 64'(es_allowin), 64'd1);
            @(posedge clk); #1;
            ds_to_es_valid = 1'b0;
            chk("bp b2b copy", {26'd0, es_to_ms_valid, rd_out, result},
                {26'd0, 1'b1, 5'd7, 32'hCAFE_0001});
            @(posedge clk); #1;
            chk("bp b2b retire", 64'(es_to_ms_valid), 64'd0);
        end

        // Flush in cycle 10 of a divide.
        ds_to_es_valid = 1'b1; op = 4'd4; op1_data = 32'd1000; op2_data = 32'd3;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush state", {61'd0, es_to_ms_valid, busy, es_allowin}, {61'd0, 3'b001});
        ds_to_es_valid = 1'b1; op = 4'd9; op1_data = 32'h55; flush = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0; flush = 1'b0;
        chk("flush blocks capture", {62'd0, es_to_ms_valid, es_allowin}, {62'd0, 2'b01});
        do_op("mul_3x4", 4'd0, 32'd3, 32'd4, 32'd12, 2, 0);

        // Asynchronous reset in the middle of a multiply.
        ds_to_es_valid = 1'b1; op = 4'd0; op1_data = 32'd6; op2_data = 32'd7;
        rd_in = 5'd9; rd_wen_in = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async reset", {25'd0, es_to_ms_valid, busy, es_allowin, rd_wen_out, rd_out, result},
               {25'd0, 4'b0010, 5'd0, 32'd0});
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post reset idle", 64'(es_to_ms_valid), 64'd0);
        end
        do_op("post reset mulh", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 2, 0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op("random", ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb),
                  $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_muldiv_stage.md
EXE_MULDIV_STAGE -- requirements
Module: exe_muldiv_stage

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 32, 64.
REQ-002 Parameter MUL_LAT, default 2: cycles in stage for multiply ops; legal 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ds_to_es_valid  input  1  upstream has an op.
REQ-006 es_allowin  output  1  stage can accept an op this cycle.
REQ-007 es_to_ms_valid  output  1  result valid toward memory stage.
REQ-008 ms_allowin  input  1  downstream accepts this cycle.
REQ-009 flush  input  1  kill the op held in the stage.
REQ-010 op  input  4  operation select; encoding in REQ-017.
REQ-011 op1_data, op2_data  input  XLEN each  rs1/rs2 operand values.
REQ-012 rd_in  input  5  destination register; rd_wen_in  input  1  writeback enable.
REQ-013 result  output  XLEN  computed value, stable while es_to_ms_valid && !ms_allowin.
REQ-014 rd_out  output  5; rd_wen_out  output  1  (rd_wen_in registered, gated by es_valid).
REQ-015 busy  output  1  high while es_valid && !es_ready_go.

Function
REQ-016 Op is accepted on an edge where ds_to_es_valid && es_allowin && !flush; op, operands, rd, and rd_wen are captured into stage registers.
REQ-017 op encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8-15 COPY1 (result = op1_data).
REQ-018 es_allowin = !es_valid || (es_ready_go && ms_allowin).
REQ-019 es_to_ms_valid = es_valid && es_ready_go.
REQ-020 FSM states: IDLE, MUL, DIV, DONE; the capture edge enters MUL, DIV, or DONE by op class and special case.
REQ-021 The capture cycle counts as cycle 1 in stage.
REQ-022 COPY1: es_ready_go in cycle 1.
REQ-023 MUL class: es_ready_go in cycle MUL_LAT.
- MUL returns the low XLEN bits of the 2*XLEN product.
- MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned; each returns the high XLEN bits.
REQ-024 DIV class uses an iterative restoring divider at 1 quotient bit per cycle; es_ready_go in cycle XLEN+1.
- Signed ops divide magnitudes, then correct signs.
- Quotient sign is sign(op1)^sign(op2); remainder sign is sign(op1).
REQ-025 Divisor = 0: quotient = all ones, remainder = op1; ready in cycle 1, no iteration.
REQ-026 Signed overflow (op1 = -2^(XLEN-1), op2 = -1) for DIV/REM: quotient = op1, remainder = 0; ready in cycle 1.
REQ-027 DONE holds result, rd_out, and rd_wen_out unchanged until ms_allowin.
- Leaving DONE: to IDLE, or directly into the next op's state if a new op is captured on the same edge (back-to-back, no bubble).
REQ-028 Counter width is clog2(XLEN+2); the counter resets to 0 on each capture and never wraps during an op.
REQ-029 flush takes priority over capture and completion: next edge es_valid=0, FSM=IDLE, counter=0; ops offered while flush=1 are not captured.
REQ-030 es_allowin is low while busy; upstream holds its op and operands.
REQ-031 If ms_allowin is low at completion, the stage stays in DONE with es_to_ms_valid=1; the result is not recomputed.

Reset
REQ-032 rst_n low asynchronously forces:
- es_valid=0, FSM=IDLE, counter=0, all stage registers 0;
- outputs: es_to_ms_valid=0, busy=0, result=0, rd_out=0, rd_wen_out=0, es_allowin=1.
REQ-033 Reset mid-divide abandons the op; after rst_n rises, the first captured op behaves as from IDLE.

Verification
REQ-034 XLEN=32, MUL_LAT=2, MULHU 0xFFFFFFFF x 0xFFFFFFFF, ms_allowin=1 -> es_to_ms_valid in cycle 2, result=0xFFFFFFFE; MUL with same operands -> 0x00000001.
REQ-035 DIV -7 / 2 -> ready in cycle 33, busy in cycles 1-32, result=0xFFFFFFFD; REM with same operands -> 0xFFFFFFFF.
REQ-036 DIVU 5 / 0 -> result=0xFFFFFFFF in cycle 1; REM 0x80000000 / 0xFFFFFFFF -> result=0 in cycle 1.
REQ-037 DIVU 100/7 completes with ms_allowin=0 for 3 cycles -> result=14 held stable, es_allowin=0; on ms_allowin=1 a waiting COPY1 is captured on the same edge.
REQ-038 flush in cycle 10 of a DIV -> next cycle es_valid=0, busy=0, es_allowin=1; a following MUL 3x4 returns 12.
REQ-039 rst_n pulsed low mid-MUL (asynchronous to clk) -> outputs at reset values immediately; no es_to_ms_valid until a new op is captured.
